// File: rtl/bru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bru_pkg
// Description : Shared constants for the branch resolve unit. This package
//               holds the branch_op encodings, the 2-bit saturating counter
//               states, the BHT reset value and the counter-update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bru_pkg;

  // branch_op encodings; every code above C_OP_BLTZAL is a non-branch
  localparam logic [3:0] C_OP_BEQ    = 4'b0000;
  localparam logic [3:0] C_OP_BNE    = 4'b0001;
  localparam logic [3:0] C_OP_BGEZ   = 4'b0010;
  localparam logic [3:0] C_OP_BGTZ   = 4'b0011;
  localparam logic [3:0] C_OP_BLEZ   = 4'b0100;
  localparam logic [3:0] C_OP_BLTZ   = 4'b0101;
  localparam logic [3:0] C_OP_BGEZAL = 4'b0110;
  localparam logic [3:0] C_OP_BLTZAL = 4'b0111;

  typedef logic [1:0] ctr_t;

  // 2-bit counter states
  localparam ctr_t C_CTR_SNT   = 2'b00;
  localparam ctr_t C_CTR_WNT   = 2'b01;
  localparam ctr_t C_CTR_WT    = 2'b10;
  localparam ctr_t C_CTR_ST    = 2'b11;
  localparam ctr_t C_CTR_RESET = C_CTR_WNT;

  // Saturating step toward taken or toward not-taken
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    if (taken)
      return (c == C_CTR_ST) ? c : ctr_t'(c + 2'd1);
    else
      return (c == C_CTR_SNT) ? c : ctr_t'(c - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bru_bht.sv
`default_nettype none
// ============================================================================
// Module      : bru_bht
// Description : Branch history table of 2-bit saturating counters. The table
//               is indexed by pc[log2(BHT_DEPTH)+1:2].
//   clk, rst   : clock and asynchronous active-high reset (all entries -> 01)
//   pc         : lookup/update PC
//   upd_en     : update the indexed counter at the next rising edge
//   upd_taken  : update direction (1 = increment, 0 = decrement)
//   pred_taken : combinational prediction, MSB of the indexed counter
// Revision    : 1.0 - initial release
// ============================================================================
module bru_bht
  import bru_pkg::*;
#(
  parameter int BHT_DEPTH = 16,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc,
  input  logic            upd_en,
  input  logic            upd_taken,
  output logic            pred_taken
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  ctr_t             r_ctr [BHT_DEPTH];
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_pc;

  assign w_idx       = pc[IDX_W+1:2];
  // Only the index bits of the PC select an entry
  assign w_unused_pc = ^{pc[PC_W-1:IDX_W+2], pc[1:0]};

  // The read and the update share one index. The read sees the stored
  // value, so a same-cycle update becomes visible on the following cycle.
  assign pred_taken = r_ctr[w_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_ctr[i] <= C_CTR_RESET;
    end else if (upd_en) begin
      r_ctr[w_idx] <= ctr_next(r_ctr[w_idx], upd_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves decode-stage branches with a 1-cycle latency and
//               reports mispredictions against a 2-bit-counter BHT.
//   clk, rst         : clock and asynchronous active-high reset
//   valid_in         : branch candidate present
//   stall            : hold all state and outputs
//   flush            : discard the candidate and the pending result
//                      (flush takes priority over stall)
//   pc_in, a, b      : candidate PC and the rs/rt operands
//   branch_op        : branch encoding (see bru_pkg)
//   pred_taken       : combinational BHT prediction for pc_in
//   res_*            : registered resolution of the last accepted branch
//   perf_branches    : accepted-branch count
//   perf_mispredicts : mispredicted-branch count
// Configuration: define BRU_PERF_CNT_EN to build the statistics counters.
//   When it is undefined, both perf outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        branch_op,
  output logic              pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              res_mispredict,
  output logic              res_link,
  output logic [PC_W-1:0]   res_pc,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
);

  logic            w_accept;
  logic            w_taken;
  logic            w_link;
  logic            w_mispredict;
  logic            w_a_neg;
  logic            w_a_zero;
  logic            r_res_valid;
  logic            r_res_taken;
  logic            r_res_mispredict;
  logic            r_res_link;
  logic [PC_W-1:0] r_res_pc;

  assign w_accept = valid_in & (branch_op <= C_OP_BLTZAL) & ~stall & ~flush;
  assign w_a_neg  = a[DATA_W-1];
  assign w_a_zero = (a == '0);
  assign w_link   = (branch_op == C_OP_BGEZAL) | (branch_op == C_OP_BLTZAL);

  // The signed compares against zero reduce to sign and zero tests
  always_comb begin
    w_taken = 1'b0;
    case (branch_op)
      C_OP_BEQ:                w_taken = (a == b);
      C_OP_BNE:                w_taken = (a != b);
      C_OP_BGEZ, C_OP_BGEZAL:  w_taken = ~w_a_neg;
      C_OP_BGTZ:               w_taken = ~w_a_neg & ~w_a_zero;
      C_OP_BLEZ:               w_taken = w_a_neg | w_a_zero;
      C_OP_BLTZ, C_OP_BLTZAL:  w_taken = w_a_neg;
      default:                 w_taken = 1'b0;
    endcase
  end

  assign w_mispredict = w_taken ^ pred_taken;

  bru_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .PC_W      (PC_W)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc_in),
    .upd_en     (w_accept),
    .upd_taken  (w_taken),
    .pred_taken (pred_taken)
  );

  // res_valid is a one-cycle pulse per accept. The remaining fields keep
  // the last resolution so that consumers may sample them late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
      r_res_link       <= 1'b0;
      r_res_pc         <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else if (!stall) begin
      r_res_valid <= w_accept;
      if (w_accept) begin
        r_res_taken      <= w_taken;
        r_res_mispredict <= w_mispredict;
        r_res_link       <= w_link;
        r_res_pc         <= pc_in;
      end
    end
  end

  assign res_valid      = r_res_valid;
  assign res_taken      = r_res_taken;
  assign res_mispredict = r_res_mispredict;
  assign res_link       = r_res_link;
  assign res_pc         = r_res_pc;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispredicts;

  // The counters wrap naturally at 32 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (w_accept) begin
      r_perf_branches <= r_perf_branches + 32'd1;
      if (w_mispredict) r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;
`else
  assign perf_branches    = '0;
  assign perf_mispredicts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit. It uses directed
//               vector tables, a reset/perf sequence and randomized traffic
//               checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int DATA_W    = 32;
  localparam int PC_W      = 32;
  localparam int BHT_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in, stall, flush;
  logic [31:0] pc_in, a, b;
  logic [3:0]  branch_op;
  logic        pred_taken, res_valid, res_taken, res_mispredict, res_link;
  logic [31:0] res_pc, perf_branches, perf_mispredicts;

  branch_resolve_unit #(
    .DATA_W    (DATA_W),
    .PC_W      (PC_W),
    .BHT_DEPTH (BHT_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .valid_in         (valid_in),
    .stall            (stall),
    .flush            (flush),
    .pc_in            (pc_in),
    .a                (a),
    .b                (b),
    .branch_op        (branch_op),
    .pred_taken       (pred_taken),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_mispredict   (res_mispredict),
    .res_link         (res_link),
    .res_pc           (res_pc),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural reference model
  int          m_bht [BHT_DEPTH];
  bit          m_valid, m_taken, m_mis, m_link;
  logic [31:0] m_pc, m_pb, m_pm;

  typedef struct {
    bit          v, s, f;
    logic [3:0]  op;
    logic [31:0] pc, a, b;
    bit          e_pred, e_v, e_t, e_m, e_l;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
    m_valid = 0; m_taken = 0; m_mis = 0; m_link = 0;
    m_pc = 0; m_pb = 0; m_pm = 0;
  endfunction

  function automatic int model_idx(input logic [31:0] pc);
    return int'((pc >> 2) % BHT_DEPTH);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return m_bht[model_idx(pc)] >= 2;
  endfunction

  function automatic bit model_cond(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:       return x == y;
      4'd1:       return x != y;
      4'd2, 4'd6: return $signed(x) >= 0;
      4'd3:       return $signed(x) > 0;
      4'd4:       return $signed(x) <= 0;
      4'd5, 4'd7: return $signed(x) < 0;
      default:    return 0;
    endcase
  endfunction

  task automatic model_edge(input vec_t t);
    bit p, tk;
    int idx;
    if (t.s && !t.f) return;
    if (t.f) begin
      m_valid = 0;
    end else if (t.v && t.op <= 4'd7) begin
      idx = model_idx(t.pc);
      p   = m_bht[idx] >= 2;
      tk  = model_cond(t.op, t.a, t.b);
      m_valid = 1; m_taken = tk; m_mis = tk ^ p;
      m_link = (t.op == 4'd6) || (t.op == 4'd7);
      m_pc = t.pc;
      if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
      else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
`ifdef BRU_PERF_CNT_EN
      m_pb = m_pb + 1;
      if (tk ^ p) m_pm = m_pm + 1;
`endif
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic check_model();
    check("res_valid", res_valid, m_valid);
    check("res_taken", res_taken, m_taken);
    check("res_mispredict", res_mispredict, m_mis);
    check("res_link", res_link, m_link);
    check("res_pc", res_pc, m_pc);
    check("perf_branches", perf_branches, m_pb);
    check("perf_mispredicts", perf_mispredicts, m_pm);
  endtask

  // Called at a negedge; returns at the following negedge
  task automatic step(input vec_t t, input bit use_exp);
    valid_in = t.v; stall = t.s; flush = t.f;
    branch_op = t.op; pc_in = t.pc; a = t.a; b = t.b;
    #1;
    check("pred_taken model", pred_taken, model_pred(t.pc));
    if (use_exp) check("pred_taken vec", pred_taken, t.e_pred);
    @(posedge clk);
    model_edge(t);
    #1;
    check_model();
    if (use_exp) begin
      check("res_valid vec", res_valid, t.e_v);
      check("res_taken vec", res_taken, t.e_t);
      check("res_mispredict vec", res_mispredict, t.e_m);
      check("res_link vec", res_link, t.e_l);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input bit v, s, f, input logic [3:0] op,
                              input logic [31:0] pc, x, y,
                              input bit ep, ev, et, em, el);
    vec_t r;
    r.v = v; r.s = s; r.f = f; r.op = op; r.pc = pc; r.a = x; r.b = y;
    r.e_pred = ep; r.e_v = ev; r.e_t = et; r.e_m = em; r.e_l = el;
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_taken"}, res_taken, 0);
    check({tag, " res_mispredict"}, res_mispredict, 0);
    check({tag, " res_link"}, res_link, 0);
    check({tag, " res_pc"}, res_pc, 0);
    check({tag, " perf_branches"}, perf_branches, 0);
    check({tag, " perf_mispredicts"}, perf_mispredicts, 0);
  endtask

  initial begin
    vec_t t;
    logic [31:0] pick [5];

    valid_in = 0; stall = 0; flush = 0; branch_op = 4'hF;
    pc_in = 0; a = 0; b = 0;
    model_reset();

    // Asynchronous reset before any clock edge
    #1 rst = 1;
    #2 check_all_zero("por");
    pc_in = 32'h100; #1;
    check("por pred_taken", pred_taken, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    //      v  s  f  op    pc         a             b      pred v  t  m  l
    tbl.push_back(mk(1, 0, 0, 4'd0, 32'h100, 32'd5,        32'd5, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 32'h100, 32'd5,        32'd6, 1, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd5, 32'h104, 32'hFFFFFFFF, 32'd0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd5, 32'h104, 32'hFFFFFFFF, 32'd0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd5, 32'h104, 32'hFFFFFFFF, 32'd0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd5, 32'h104, 32'hFFFFFFFF, 32'd0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd6, 32'h108, 32'h80000000, 32'd0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'd8, 32'h108, 32'd0,        32'd0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 32'h100, 32'd5,        32'd5, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'd3, 32'h10C, 32'd0,        32'd0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd3, 32'h10C, 32'd1,        32'd0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd7, 32'h110, 32'd1,        32'd0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 4'd4, 32'h110, 32'd0,        32'd0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd1, 32'h114, 32'd1,        32'd2, 0, 1, 1, 1, 0));
    // stall, stall+flush, stall, then a fresh accept at the same index
    tbl.push_back(mk(0, 1, 0, 4'd1, 32'h114, 32'd1,        32'd2, 1, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4'd1, 32'h114, 32'd1,        32'd2, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 0, 4'd1, 32'h114, 32'd1,        32'd2, 1, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd1, 32'h114, 32'd1,        32'd2, 1, 1, 1, 0, 0));
    // flush without stall discards a candidate and leaves its counter alone
    tbl.push_back(mk(1, 0, 1, 4'd0, 32'h118, 32'd3,        32'd3, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 32'h118, 32'd3,        32'd3, 0, 1, 1, 1, 0));

    foreach (tbl[i]) step(tbl[i], 1);

    // Randomized traffic against the model
    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFFFFFF; pick[3] = 32'h80000000;
    for (int n = 0; n < 400; n++) begin
      pick[4] = $urandom;
      t.v  = ($urandom_range(0, 3) != 0);
      t.s  = ($urandom_range(0, 5) == 0);
      t.f  = ($urandom_range(0, 9) == 0);
      t.op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      t.pc = $urandom & 32'hFFFF_FF3C;
      t.a  = pick[$urandom_range(0, 4)];
      t.b  = ($urandom_range(0, 1) == 0) ? t.a : $urandom;
      step(t, 0);
    end

    // Reset mid-stream: a pending result is discarded asynchronously
    valid_in = 1; stall = 0; flush = 0; branch_op = 4'd5;
    pc_in = 32'h104; a = 32'hFFFFFFFF; b = 0;
    @(posedge clk);
    #2 rst = 1;
    #1 check_all_zero("midrst");
    check("midrst pred_taken", pred_taken, 0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // First accept after reset behaves as after power-on
    step(mk(1, 0, 0, 4'd0, 32'h100, 32'd5, 32'd5, 0, 1, 1, 1, 0), 1);

`ifdef BRU_PERF_CNT_EN
    force dut.r_perf_branches    = 32'hFFFFFFFF;
    force dut.r_perf_mispredicts = 32'hFFFFFFFF;
    #1;
    release dut.r_perf_branches;
    release dut.r_perf_mispredicts;
    m_pb = 32'hFFFFFFFF; m_pm = 32'hFFFFFFFF;
    step(mk(1, 0, 0, 4'd0, 32'h11C, 32'd7, 32'd7, 0, 1, 1, 1, 0), 1);
    check("wrap perf_branches", perf_branches, 0);
    check("wrap perf_mispredicts", perf_mispredicts, 0);
`else
    check("nocnt perf_branches", perf_branches, 0);
    check("nocnt perf_mispredicts", perf_mispredicts, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
